// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: carries the F-stage prediction to E and resolves it.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 PCSrcPredF,
  input  logic [PC_WIDTH-1:0]  PredPCTargetF,
  input  logic [1:0]           BranchOpE,
  input  logic                 CondMetE,
  input  logic [PC_WIDTH-1:0]  PCTargetE,
  input  logic [PC_WIDTH-1:0]  PCPlus4E,
  output logic                 PCSrcResE,
  output logic                 TargetMatchE,
  output logic                 BranchOpEb0,
  output logic                 MispredictE,
  output logic [PC_WIDTH-1:0]  PCRedirectE,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredictCount
);

  logic                pred_d_q;
  logic [PC_WIDTH-1:0] tgt_d_q;
  logic                valid_d_q;

  logic                pred_e_q;
  logic [PC_WIDTH-1:0] tgt_e_q;
  logic                valid_e_q;
  logic                resolved_e_q;

  logic v;
  logic is_br;
  logic is_jmp;
  logic taken;
  logic tgt_eq;
  logic mispred;

  // D-stage prediction register: flush beats stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_d_q  <= 1'b0;
      tgt_d_q   <= '0;
      valid_d_q <= 1'b0;
    end else if (FlushD) begin
      pred_d_q  <= 1'b0;
      tgt_d_q   <= '0;
      valid_d_q <= 1'b0;
    end else if (!StallD) begin
      pred_d_q  <= PCSrcPredF;
      tgt_d_q   <= PredPCTargetF;
      valid_d_q <= 1'b1;
    end
  end

  // E-stage register; a stalled mispredict is marked resolved so it fires once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_e_q     <= 1'b0;
      tgt_e_q      <= '0;
      valid_e_q    <= 1'b0;
      resolved_e_q <= 1'b0;
    end else if (FlushE) begin
      pred_e_q     <= 1'b0;
      tgt_e_q      <= '0;
      valid_e_q    <= 1'b0;
      resolved_e_q <= 1'b0;
    end else if (!StallE) begin
      pred_e_q     <= pred_d_q;
      tgt_e_q      <= tgt_d_q;
      valid_e_q    <= valid_d_q;
      resolved_e_q <= 1'b0;
    end else if (mispred) begin
      resolved_e_q <= 1'b1;
    end
  end

  assign v      = valid_e_q & ~resolved_e_q;
  assign is_br  = (BranchOpE == 2'b01);
  assign is_jmp = (BranchOpE == 2'b10);
  assign taken  = is_jmp | (is_br & CondMetE);
  assign tgt_eq = (tgt_e_q == PCTargetE);

  // Wrong direction, wrong target when both taken, or a taken alias on a non-branch
  assign mispred = v & (pred_e_q ? (~taken | ~tgt_eq) : taken);

  assign PCSrcResE    = v & taken;
  assign BranchOpEb0  = v & is_br;
  assign TargetMatchE = v & tgt_eq;
  assign MispredictE  = mispred;
  assign PCRedirectE  = !mispred ? '0 :
                        taken    ? PCTargetE : PCPlus4E;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] br_cnt_q;
  logic [CNT_WIDTH-1:0] mis_cnt_q;
  logic                 counted_q;
  logic                 cnt_br;

  assign cnt_br = v & (is_br | is_jmp) & ~counted_q;

  // Remember that a stalled E instruction was already counted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counted_q <= 1'b0;
    end else if (FlushE || !StallE) begin
      counted_q <= 1'b0;
    end else if (cnt_br) begin
      counted_q <= 1'b1;
    end
  end

  // Saturating branch and mispredict counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (cnt_br && (br_cnt_q != '1)) begin
        br_cnt_q <= br_cnt_q + 1'b1;
      end
      if (mispred && (mis_cnt_q != '1)) begin
        mis_cnt_q <= mis_cnt_q + 1'b1;
      end
    end
  end

  assign BranchCount     = br_cnt_q;
  assign MispredictCount = mis_cnt_q;
`else
  assign BranchCount     = '0;
  assign MispredictCount = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and randomized checks of the
// branch resolve unit against a small prediction-pipeline model.
module tb_branch_resolve_unit;

  localparam int PW = 32;
`ifdef BRU_PERF_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif

  logic          clk;
  logic          reset;
  logic          StallD, FlushD, StallE, FlushE;
  logic          PCSrcPredF;
  logic [PW-1:0] PredPCTargetF;
  logic [1:0]    BranchOpE;
  logic          CondMetE;
  logic [PW-1:0] PCTargetE, PCPlus4E;
  logic          PCSrcResE, TargetMatchE, BranchOpEb0, MispredictE;
  logic [PW-1:0] PCRedirectE;
  logic [CW-1:0] BranchCount, MispredictCount;

  int errs = 0;
  int checks = 0;

  branch_resolve_unit #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .StallD(StallD), .FlushD(FlushD),
    .StallE(StallE), .FlushE(FlushE),
    .PCSrcPredF(PCSrcPredF), .PredPCTargetF(PredPCTargetF),
    .BranchOpE(BranchOpE), .CondMetE(CondMetE),
    .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
    .PCSrcResE(PCSrcResE), .TargetMatchE(TargetMatchE),
    .BranchOpEb0(BranchOpEb0), .MispredictE(MispredictE),
    .PCRedirectE(PCRedirectE),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] flags;
  assign flags = {PCSrcResE, TargetMatchE, BranchOpEb0, MispredictE};

  // Reference model: a two-slot prediction pipeline plus a "fired" mark
  typedef struct packed {
    logic          valid;
    logic          pred;
    logic [PW-1:0] tgt;
  } slot_t;

  slot_t         md, me;
  logic          mres, mcd;
  logic [CW-1:0] mbc, mmc;
  logic          mv, mtaken, mmatch, mmis;
  logic [PW-1:0] mredir;
  logic [3:0]    mflags;

  always_comb begin
    mv     = me.valid && !mres;
    mtaken = (BranchOpE == 2'b10) || (BranchOpE == 2'b01 && CondMetE);
    mmatch = (me.tgt == PCTargetE);
    mmis   = 1'b0;
    mredir = '0;
    if (mv) begin
      if (me.pred && !mtaken) begin
        mmis = 1'b1; mredir = PCPlus4E;
      end else if (!me.pred && mtaken) begin
        mmis = 1'b1; mredir = PCTargetE;
      end else if (me.pred && mtaken && !mmatch) begin
        mmis = 1'b1; mredir = PCTargetE;
      end
    end
    mflags = {mv && mtaken, mv && mmatch,
              mv && (BranchOpE == 2'b01), mmis};
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      md <= '0; me <= '0; mres <= 1'b0; mcd <= 1'b0;
      mbc <= '0; mmc <= '0;
    end else begin
      if (FlushD) md <= '0;
      else if (!StallD) md <= '{1'b1, PCSrcPredF, PredPCTargetF};
      if (FlushE) begin
        me <= '0; mres <= 1'b0; mcd <= 1'b0;
      end else if (!StallE) begin
        me <= md; mres <= 1'b0; mcd <= 1'b0;
      end else begin
        if (mmis) mres <= 1'b1;
        if (mv && BranchOpE inside {2'b01, 2'b10}) mcd <= 1'b1;
      end
`ifdef BRU_PERF_CNT_EN
      if (mv && !mcd && BranchOpE inside {2'b01, 2'b10}
          && mbc != {CW{1'b1}}) mbc <= mbc + 1'b1;
      if (mmis && mmc != {CW{1'b1}}) mmc <= mmc + 1'b1;
`endif
    end
  end

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic clear_ctl();
    StallD = 0; FlushD = 0; StallE = 0; FlushE = 0;
  endtask

  // Push one prediction from F and a neutral bubble behind it
  task automatic load_pred(input logic p, input logic [PW-1:0] t);
    clear_ctl();
    PCSrcPredF = p; PredPCTargetF = t;
    adv();
    BranchOpE = 2'b00; PCSrcPredF = 1'b0; PredPCTargetF = '0;
    adv();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      StallD = 1'($urandom); FlushD = 1'($urandom);
      StallE = 1'($urandom); FlushE = 1'($urandom);
      PCSrcPredF = 1'($urandom); PredPCTargetF = $urandom;
      BranchOpE = 2'($urandom); CondMetE = 1'($urandom);
      PCTargetE = $urandom; PCPlus4E = $urandom;
      #1;
      checks++;
      if ({flags, PCRedirectE, BranchCount, MispredictCount} !== '0) begin
        errs++;
        $display("FAIL reset_outputs: got flags=%b redir=%h bc=%0d mc=%0d exp all 0",
                 flags, PCRedirectE, BranchCount, MispredictCount);
      end
      adv();
    end
  endtask

  task automatic test_latency();
    clear_ctl();
    BranchOpE = 2'b00; CondMetE = 0; PCTargetE = '0; PCPlus4E = '0;
    PCSrcPredF = 1'b1; PredPCTargetF = 32'h100;
    reset = 1'b1;
    adv();
    PCSrcPredF = 1'b0; PredPCTargetF = '0;
    BranchOpE = 2'b10; PCTargetE = 32'h100; PCPlus4E = 32'h104;
    #1;
    checks++;
    if (flags !== 4'b0000) begin
      errs++;
      $display("FAIL latency_cycle1: got flags=%b exp 0000", flags);
    end
    adv();
    #1;
    checks++;
    if (flags !== 4'b1100 || PCRedirectE !== '0) begin
      errs++;
      $display("FAIL latency_cycle2: got flags=%b redir=%h exp 1100 0",
               flags, PCRedirectE);
    end
  endtask

  task automatic test_cond_mispredict();
    load_pred(1'b0, 32'h0);
    BranchOpE = 2'b01; CondMetE = 1; PCTargetE = 32'h200; PCPlus4E = 32'h1004;
    #1;
    checks++;
    if (flags !== 4'b1011 || PCRedirectE !== 32'h200) begin
      errs++;
      $display("FAIL cond_not_taken_pred: got flags=%b redir=%h exp 1011 200",
               flags, PCRedirectE);
    end
  endtask

  task automatic test_target();
    load_pred(1'b1, 32'h300);
    BranchOpE = 2'b10; CondMetE = 0; PCTargetE = 32'h304; PCPlus4E = 32'h404;
    #1;
    checks++;
    if (flags !== 4'b1001 || PCRedirectE !== 32'h304) begin
      errs++;
      $display("FAIL target_mismatch: got flags=%b redir=%h exp 1001 304",
               flags, PCRedirectE);
    end
    load_pred(1'b1, 32'h300);
    BranchOpE = 2'b10; PCTargetE = 32'h300;
    #1;
    checks++;
    if (flags !== 4'b1100 || PCRedirectE !== '0) begin
      errs++;
      $display("FAIL target_match: got flags=%b redir=%h exp 1100 0",
               flags, PCRedirectE);
    end
  endtask

  task automatic test_alias();
    load_pred(1'b1, 32'h500);
    BranchOpE = 2'b00; CondMetE = 1; PCTargetE = 32'h888; PCPlus4E = 32'h44;
    #1;
    checks++;
    if (flags !== 4'b0001 || PCRedirectE !== 32'h44) begin
      errs++;
      $display("FAIL alias_none: got flags=%b redir=%h exp 0001 44",
               flags, PCRedirectE);
    end
    load_pred(1'b1, 32'h500);
    BranchOpE = 2'b11;
    #1;
    checks++;
    if (flags !== 4'b0001 || PCRedirectE !== 32'h44) begin
      errs++;
      $display("FAIL alias_reserved: got flags=%b redir=%h exp 0001 44",
               flags, PCRedirectE);
    end
  endtask

  task automatic test_stall_resolve();
    int nmis, nres, ntrain;
    nmis = 0; nres = 0; ntrain = 0;
    load_pred(1'b0, 32'h0);
    BranchOpE = 2'b01; CondMetE = 1; PCTargetE = 32'h600; PCPlus4E = 32'h604;
    StallD = 1; StallE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      nmis += int'(MispredictE);
      nres += int'(PCSrcResE);
      ntrain += int'(BranchOpEb0);
      adv();
    end
    checks++;
    if (nmis != 1 || nres != 1 || ntrain != 1) begin
      errs++;
      $display("FAIL stall_single_pulse: got mis=%0d res=%0d train=%0d exp 1 1 1",
               nmis, nres, ntrain);
    end
    FlushD = 1;
    adv();
    FlushD = 0; StallE = 0;
    adv();
    BranchOpE = 2'b10;
    #1;
    checks++;
    if (flags !== 4'b0000 || PCRedirectE !== '0) begin
      errs++;
      $display("FAIL flushd_over_stalld: got flags=%b redir=%h exp 0000 0",
               flags, PCRedirectE);
    end
    clear_ctl();
    adv();
  endtask

  task automatic test_flush_e();
    load_pred(1'b0, 32'h0);
    BranchOpE = 2'b01; CondMetE = 1; PCTargetE = 32'h700; PCPlus4E = 32'h704;
    FlushE = 1; StallE = 1;
    #1;
    checks++;
    if (MispredictE !== 1'b1 || PCRedirectE !== 32'h700) begin
      errs++;
      $display("FAIL flushe_mispredict: got mis=%b redir=%h exp 1 700",
               MispredictE, PCRedirectE);
    end
    adv();
    FlushE = 0;
    #1;
    checks++;
    if (flags !== 4'b0000) begin
      errs++;
      $display("FAIL flushe_next_invalid: got flags=%b exp 0000", flags);
    end
    clear_ctl();
    adv();
  endtask

  task automatic test_reset_mid();
    clear_ctl();
    PCSrcPredF = 1; PredPCTargetF = 32'h300;
    adv();
    adv();
    BranchOpE = 2'b10; PCTargetE = 32'h304; PCPlus4E = 32'h404;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({flags, PCRedirectE} !== '0) begin
      errs++;
      $display("FAIL reset_mid_async: got flags=%b redir=%h exp 0000 0",
               flags, PCRedirectE);
    end
    adv();
    reset = 1'b1;
    adv();
    #1;
    checks++;
    if ({flags, PCRedirectE} !== '0) begin
      errs++;
      $display("FAIL reset_mid_no_pulse: got flags=%b redir=%h exp 0000 0",
               flags, PCRedirectE);
    end
    BranchOpE = 2'b00;
    adv();
  endtask

  task automatic test_random();
    logic [PW-1:0] pool [4];
    pool[0] = 32'h100; pool[1] = 32'h104;
    pool[2] = 32'h200; pool[3] = 32'h2000;
    for (int i = 0; i < 400; i++) begin
      StallD = ($urandom_range(0, 7) == 0);
      FlushD = ($urandom_range(0, 9) == 0);
      StallE = ($urandom_range(0, 5) == 0);
      FlushE = ($urandom_range(0, 9) == 0);
      PCSrcPredF = 1'($urandom);
      PredPCTargetF = pool[$urandom_range(0, 3)];
      BranchOpE = 2'($urandom);
      CondMetE = 1'($urandom);
      PCTargetE = pool[$urandom_range(0, 3)];
      PCPlus4E = ($urandom_range(0, 3) == 0) ? pool[1] : $urandom;
      #1;
      checks++;
      if (flags !== mflags || PCRedirectE !== mredir) begin
        errs++;
        $display("FAIL random_outputs[%0d]: got flags=%b redir=%h exp %b %h",
                 i, flags, PCRedirectE, mflags, mredir);
      end
      checks++;
      if (BranchCount !== mbc || MispredictCount !== mmc) begin
        errs++;
        $display("FAIL random_counters[%0d]: got bc=%0d mc=%0d exp %0d %0d",
                 i, BranchCount, MispredictCount, mbc, mmc);
      end
      adv();
    end
    clear_ctl();
    BranchOpE = 2'b00;
  endtask

  task automatic test_perf();
`ifdef BRU_PERF_CNT_EN
    reset = 1'b0;
    adv();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_pred(1'b1, 32'h300);
      BranchOpE = 2'b10; CondMetE = 0; PCTargetE = 32'h300; PCPlus4E = 32'h404;
    end
    for (int i = 0; i < 2; i++) begin
      load_pred(1'b0, 32'h0);
      BranchOpE = 2'b01; CondMetE = 1; PCTargetE = 32'h200; PCPlus4E = 32'h204;
    end
    adv();
    BranchOpE = 2'b00;
    #1;
    checks++;
    if (BranchCount !== 4'd5 || MispredictCount !== 4'd2) begin
      errs++;
      $display("FAIL perf_counts: got bc=%0d mc=%0d exp 5 2",
               BranchCount, MispredictCount);
    end
    PCSrcPredF = 0; PredPCTargetF = '0;
    BranchOpE = 2'b10; PCTargetE = 32'h900; PCPlus4E = 32'h904;
    for (int i = 0; i < 20; i++) adv();
    BranchOpE = 2'b00;
    #1;
    checks++;
    if (BranchCount !== 4'hF || MispredictCount !== 4'hF) begin
      errs++;
      $display("FAIL perf_saturate: got bc=%0d mc=%0d exp 15 15",
               BranchCount, MispredictCount);
    end
`else
    load_pred(1'b0, 32'h0);
    BranchOpE = 2'b01; CondMetE = 1; PCTargetE = 32'h200; PCPlus4E = 32'h204;
    adv();
    BranchOpE = 2'b00;
    #1;
    checks++;
    if (BranchCount !== '0 || MispredictCount !== '0) begin
      errs++;
      $display("FAIL perf_tied_off: got bc=%0d mc=%0d exp 0 0",
               BranchCount, MispredictCount);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    StallD = 0; FlushD = 0; StallE = 0; FlushE = 0;
    PCSrcPredF = 0; PredPCTargetF = '0;
    BranchOpE = 2'b00; CondMetE = 0; PCTargetE = '0; PCPlus4E = '0;
    adv();
    test_reset();
    test_latency();
    test_cond_mispredict();
    test_target();
    test_alias();
    test_stall_resolve();
    test_flush_e();
    test_reset_mid();
    test_random();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
